// File: rtl/vlc_switch_conditioner.sv
// Switch conditioner: per-channel synchronizer and debouncer, then priority resolution into registered turn/hazard levels.
// Optional build macro VLC_HAZARD_ON_CONFLICT_EN: a jammed stalk (left and right both on) resolves to hazard.
module vlc_switch_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_left_raw,
   input  logic sw_right_raw,
   input  logic sw_emergency_raw,
   output logic turn_left,
   output logic turn_right,
   output logic emergency,
   output logic conflict,
   output logic change
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef VLC_HAZARD_ON_CONFLICT_EN
   localparam bit HAZARD_ON_CONFLICT = 1'b1;
`else
   localparam bit HAZARD_ON_CONFLICT = 1'b0;
`endif

   // Channel order everywhere: bit 0 left, bit 1 right, bit 2 emergency.
   logic [2:0] raw;
   logic [2:0] db;
   logic [2:0] res;
   logic [2:0] out_q;

   assign raw = {sw_emergency_raw, sw_right_raw, sw_left_raw};

   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CW-1:0]          cnt;
      logic                   db_q;
      logic                   sync_out;

      assign sync_out = sync_q[SYNC_STAGES-1];
      assign db[c]    = db_q;

      // Any matching sample restarts the count, so only an unbroken run flips db.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            db_q   <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw[c]};
            if (sync_out == db_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               db_q <= ~db_q;
               cnt  <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      res = 3'b000;
      if (db[2]) begin
         res = 3'b100;
      end else if (db[0] && !db[1]) begin
         res = 3'b001;
      end else if (!db[0] && db[1]) begin
         res = 3'b010;
      end else if (db[0] && db[1]) begin
         res = HAZARD_ON_CONFLICT ? 3'b100 : 3'b000;
      end
   end

   // change compares against the registered value so it lines up with the new output.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= 3'b000;
         conflict <= 1'b0;
         change   <= 1'b0;
      end else begin
         out_q    <= res;
         conflict <= db[0] & db[1];
         change   <= (res != out_q);
      end
   end

   assign turn_left  = out_q[0];
   assign turn_right = out_q[1];
   assign emergency  = out_q[2];

endmodule

// File: tb/tb_vlc_switch_conditioner.sv
// Bench for vlc_switch_conditioner: directed scenarios plus random switch activity, checked by a
// window-based debounce model feeding an expected queue that a negedge monitor drains.
`timescale 1ns/1ps
module tb_vlc_switch_conditioner;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LAT  = SYNC + DEB;

`ifdef VLC_HAZARD_ON_CONFLICT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_left_raw = 1'b0;
  logic sw_right_raw = 1'b0;
  logic sw_emergency_raw = 1'b0;
  logic turn_left, turn_right, emergency, conflict, change;

  vlc_switch_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_left_raw(sw_left_raw),
    .sw_right_raw(sw_right_raw),
    .sw_emergency_raw(sw_emergency_raw),
    .turn_left(turn_left),
    .turn_right(turn_right),
    .emergency(emergency),
    .conflict(conflict),
    .change(change)
  );

  // clock / reset
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // expected word layout: {conflict, change, emergency, turn_right, turn_left}
  logic [4:0] exp_q[$];

  // reference model state: raw history since reset, debounced levels, edge of last flip
  logic [2:0] hist[$];
  logic [2:0] m_db = 3'b000;
  logic [2:0] m_out = 3'b000;
  int m_last[3];
  int m_n = 0;

  // synchronized level the debouncer sees at edge k: raw captured SYNC edges earlier, 0 before that
  function automatic logic sample_at(input int k, input int c);
    if (k < SYNC) return 1'b0;
    return hist[k-SYNC][c];
  endfunction

  function automatic logic [2:0] resolve(input logic [2:0] d);
    if (d[2]) return 3'b100;
    if (d[0] && !d[1]) return 3'b001;
    if (!d[0] && d[1]) return 3'b010;
    if (d[0] && d[1]) return HAZ ? 3'b100 : 3'b000;
    return 3'b000;
  endfunction

  // db flips at edge n when the last DEB synchronized samples, all after the previous flip, disagree with it
  always @(posedge clk) begin
    logic [2:0] nxt;
    logic [2:0] new_db;
    bit flip;
    if (rst) begin
      hist.delete();
      m_db = 3'b000;
      m_out = 3'b000;
      m_n = 0;
      for (int c = 0; c < 3; c++) m_last[c] = -1;
      exp_q.push_back(5'b00000);
    end else begin
      hist.push_back({sw_emergency_raw, sw_right_raw, sw_left_raw});
      nxt = resolve(m_db);
      exp_q.push_back({m_db[0] & m_db[1], nxt != m_out, nxt});
      m_out = nxt;
      new_db = m_db;
      for (int c = 0; c < 3; c++) begin
        if (m_n - m_last[c] >= DEB) begin
          flip = 1'b1;
          for (int k = m_n - DEB + 1; k <= m_n; k++)
            if (sample_at(k, c) == m_db[c]) flip = 1'b0;
          if (flip) begin
            new_db[c] = ~m_db[c];
            m_last[c] = m_n;
          end
        end
      end
      m_db = new_db;
      m_n++;
    end
  end

  // scoreboard monitor: the DUT presents a result every cycle
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {conflict, change, emergency, turn_right, turn_left};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL outputs t=%0t {conflict,change,emg,right,left} got=%b expected=%b", $time, got, exp);
      end
    end
  end

  // driver tasks: all return aligned to a negedge
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input logic l, input logic r, input logic e);
    sw_left_raw = l;
    sw_right_raw = r;
    sw_emergency_raw = e;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wait_cycles(n);
    rst = 1'b0;
  endtask

  // edges counted from the first edge after the call; turn_left should appear after edge LAT
  task automatic check_rise(input string name);
    int got;
    got = -1;
    for (int i = 0; i < LAT + 20 && got < 0; i++) begin
      @(negedge clk);
      if (turn_left === 1'b1) got = i;
    end
    compared++;
    if (got != LAT) begin
      mismatched++;
      $display("FAIL %s rise_edge got=%0d expected=%0d (-1 = timeout)", name, got, LAT);
    end
  endtask

  initial begin
    @(negedge clk);
    // 1: reset with quiet inputs, then idle
    set_raw(0, 0, 0);
    do_reset(3);
    wait_cycles(50);

    // 2: single left press, exact latency
    set_raw(1, 0, 0);
    check_rise("left_latency");
    wait_cycles(10);

    // 3: bouncing left, then settle high
    set_raw(0, 0, 0);
    do_reset(2);
    for (int t = 0; t < 8; t++) begin
      set_raw(~sw_left_raw, 0, 0);
      wait_cycles(5);
    end
    set_raw(1, 0, 0);
    check_rise("bounce_then_hold");
    wait_cycles(5);

    // 4: left and right together
    set_raw(0, 0, 0);
    do_reset(2);
    set_raw(1, 1, 0);
    wait_cycles(30);

    // 5: emergency overrides a held left, then releases
    set_raw(0, 0, 0);
    do_reset(2);
    set_raw(1, 0, 0);
    wait_cycles(25);
    set_raw(1, 0, 1);
    wait_cycles(25);
    set_raw(1, 0, 0);
    wait_cycles(25);

    // 6: reset mid-count with left held through it
    set_raw(0, 0, 0);
    do_reset(2);
    set_raw(1, 0, 0);
    wait_cycles(10);
    do_reset(1);
    check_rise("reset_mid_count");
    wait_cycles(5);

    // random switch activity: short glitches, long holds, occasional resets
    set_raw(0, 0, 0);
    do_reset(2);
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
      set_raw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) wait_cycles($urandom_range(1, DEB - 1));
      else wait_cycles($urandom_range(DEB, 2 * LAT));
    end
    set_raw(0, 0, 0);
    wait_cycles(2 * LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
